// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
//   Shared types and elaboration helpers for the PWM period stepper.
//   - pwm_state_e : run/idle state of the PWM generator.
//   - params_ok() : parameter legality check, evaluated at elaboration.
// ---------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

    // True when the parameter set describes a usable stepper:
    //   2 <= PERIOD_MIN < PERIOD_MAX <= 2^N-1,
    //   PERIOD_MIN <= PERIOD_INIT <= PERIOD_MAX,
    //   1 <= STEP <= 2^N-1 (keeps step arithmetic inside N+1 bits).
    function automatic bit params_ok(input int n, input int pmin, input int pmax,
                                     input int pinit, input int step);
        longint lim;
        lim = (longint'(1) << n) - 1;
        return (n >= 2) && (n <= 31) &&
               (pmin >= 2) && (longint'(pmax) <= lim) && (pmax > pmin) &&
               (pinit >= pmin) && (pinit <= pmax) &&
               (step >= 1) && (longint'(step) <= lim);
    endfunction

endpackage

// File: rtl/period_step_sat.sv
// ---------------------------------------------------------------------------
// period_step_sat
//   Holds the active PWM period and steps it up or down by STEP with
//   saturation at PERIOD_MIN / PERIOD_MAX when load is strobed.
// Ports:
//   clk        in   system clock
//   n_reset    in   asynchronous active-low reset
//   load       in   apply one step this edge
//   direction  in   1 = lengthen, 0 = shorten
//   period     out  active period (registered)
//   at_min     out  period == PERIOD_MIN (registered)
//   at_max     out  period == PERIOD_MAX (registered)
// ---------------------------------------------------------------------------
module period_step_sat
    import pwm_pkg::*;
#(
    parameter int N           = 8,
    parameter int PERIOD_MIN  = 4,
    parameter int PERIOD_MAX  = 255,
    parameter int PERIOD_INIT = 255,
    parameter int STEP        = 1
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         load,
    input  logic         direction,
    output logic [N-1:0] period,
    output logic         at_min,
    output logic         at_max
);

    localparam logic [N:0] MIN_W  = (N+1)'(PERIOD_MIN);
    localparam logic [N:0] MAX_W  = (N+1)'(PERIOD_MAX);
    localparam logic [N:0] STEP_W = (N+1)'(STEP);
    localparam bit INIT_AT_MIN = (PERIOD_INIT == PERIOD_MIN);
    localparam bit INIT_AT_MAX = (PERIOD_INIT == PERIOD_MAX);

    logic [N:0]   wide;
    logic [N:0]   up_sum;
    logic [N:0]   dn_diff;
    logic [N-1:0] period_nxt;

    // One extra bit so the sum cannot wrap and the difference is only
    // formed after proving it cannot go negative.
    always_comb begin
        wide       = {1'b0, period};
        up_sum     = wide + STEP_W;
        dn_diff    = wide - STEP_W;
        period_nxt = period;
        if (direction) begin
            period_nxt = (up_sum > MAX_W) ? MAX_W[N-1:0] : up_sum[N-1:0];
        end else begin
            if ((wide < STEP_W) || (dn_diff < MIN_W)) begin
                period_nxt = MIN_W[N-1:0];
            end else begin
                period_nxt = dn_diff[N-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            period <= N'(PERIOD_INIT);
            at_min <= INIT_AT_MIN;
            at_max <= INIT_AT_MAX;
        end else if (load) begin
            period <= period_nxt;
            at_min <= (period_nxt == MIN_W[N-1:0]);
            at_max <= (period_nxt == MAX_W[N-1:0]);
        end
    end

endmodule

// File: rtl/pwm_period_stepper.sv
// ---------------------------------------------------------------------------
// pwm_period_stepper
//   PWM generator whose period is stepped once per PWM cycle on request.
//   Period and duty are double-buffered: both change only at the wrap edge,
//   so pwm_out never glitches mid-cycle.
// Ports:
//   clk            in   system clock
//   n_reset        in   asynchronous active-low reset
//   enable         in   1 = RUN, 0 = IDLE
//   modify_period  in   step request (level or pulse)
//   direction      in   1 = lengthen, 0 = shorten (sampled at the wrap)
//   duty [N]       in   requested high time, loaded at the wrap
//   pwm_out        out  registered PWM output, aligned with the counter
//   period [N]     out  active period
//   period_wrap    out  one-cycle pulse on the first cycle of each period
//   at_min         out  period == PERIOD_MIN
//   at_max         out  period == PERIOD_MAX
//
// Request semantics: modify_period has no ready/acknowledge. Any RUN cycle
// with modify_period=1 sets mod_req; the next wrap edge consumes it (or a
// request present in the wrap cycle itself) and applies exactly one step.
// A held level therefore yields one step per PWM period.
// ---------------------------------------------------------------------------
module pwm_period_stepper
    import pwm_pkg::*;
#(
    parameter int N           = 8,
    parameter int PERIOD_MIN  = 4,
    parameter int PERIOD_MAX  = 255,
    parameter int PERIOD_INIT = 255,
    parameter int STEP        = 1
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         enable,
    input  logic         modify_period,
    input  logic         direction,
    input  logic [N-1:0] duty,
    output logic         pwm_out,
    output logic [N-1:0] period,
    output logic         period_wrap,
    output logic         at_min,
    output logic         at_max
);

    if (!params_ok(N, PERIOD_MIN, PERIOD_MAX, PERIOD_INIT, STEP)) begin : g_bad_params
        $error("pwm_period_stepper: illegal parameter set");
    end

    pwm_state_e   state;
    logic [N-1:0] counter;
    logic [N-1:0] counter_inc;
    logic [N-1:0] duty_act;
    logic [N-1:0] duty_eff;
    logic         mod_req;
    logic         wrap_hit;
    logic         step_load;

    always_comb begin
        counter_inc = counter + N'(1);
        wrap_hit    = (state == RUN) && (counter == (period - N'(1)));
        duty_eff    = (duty_act < period) ? duty_act : period;
        // A falling enable in the wrap cycle wins: no step is applied.
        step_load   = wrap_hit && enable && (mod_req || modify_period);
    end

    period_step_sat #(
        .N           (N),
        .PERIOD_MIN  (PERIOD_MIN),
        .PERIOD_MAX  (PERIOD_MAX),
        .PERIOD_INIT (PERIOD_INIT),
        .STEP        (STEP)
    ) u_period (
        .clk       (clk),
        .n_reset   (n_reset),
        .load      (step_load),
        .direction (direction),
        .period    (period),
        .at_min    (at_min),
        .at_max    (at_max)
    );

    // At a period start the new period is always >= PERIOD_MIN >= 2, so
    // (0 < min(duty, new_period)) reduces to (duty != 0).
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            counter     <= '0;
            duty_act    <= '0;
            mod_req     <= 1'b0;
            pwm_out     <= 1'b0;
            period_wrap <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    counter     <= '0;
                    period_wrap <= 1'b0;
                    mod_req     <= 1'b0;
                    if (enable) begin
                        state    <= RUN;
                        duty_act <= duty;
                        pwm_out  <= (duty != '0);
                    end else begin
                        pwm_out  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state       <= IDLE;
                        counter     <= '0;
                        pwm_out     <= 1'b0;
                        mod_req     <= 1'b0;
                        period_wrap <= 1'b0;
                    end else if (wrap_hit) begin
                        counter     <= '0;
                        period_wrap <= 1'b1;
                        duty_act    <= duty;
                        pwm_out     <= (duty != '0);
                        mod_req     <= 1'b0;
                    end else begin
                        counter     <= counter_inc;
                        period_wrap <= 1'b0;
                        pwm_out     <= (counter_inc < duty_eff);
                        if (modify_period) begin
                            mod_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    counter     <= '0;
                    pwm_out     <= 1'b0;
                    period_wrap <= 1'b0;
                    mod_req     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_period_stepper.md
Name: pwm_period_stepper

Overview:
- PWM generator stage directly downstream of the period-modify enabler.
- Consumes the enabler's modify-period strobe and steps the active PWM period once per PWM cycle, up or down, with saturation.
- Period and duty are double-buffered and take effect only at a period boundary, so pwm_out never glitches mid-cycle.
- Feeds the board-level PWM pin and exposes a per-period wrap pulse for downstream sequencing.

Parameters:
- N, 8: width of counter, period and duty.
- PERIOD_MIN, 4: lower saturation bound for the period (>=2).
- PERIOD_MAX, 255: upper saturation bound (<=2^N-1, >PERIOD_MIN).
- PERIOD_INIT, 255: period after reset (PERIOD_MIN..PERIOD_MAX).
- STEP, 1: period increment or decrement per applied request (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_reset  in  1  asynchronous active-low reset.
- enable  in  1  run PWM when high; IDLE when low.
- modify_period  in  1  step request from the upstream enabler (level or pulse).
- direction  in  1  1 = lengthen period, 0 = shorten; sampled at apply time.
- duty  in  N  requested high-time in cycles; loaded at period boundary.
- pwm_out  out  1  registered PWM output.
- period  out  N  currently active period.
- period_wrap  out  1  one-cycle pulse on first cycle of each new period (not on IDLE->RUN entry).
- at_min  out  1  period == PERIOD_MIN.
- at_max  out  1  period == PERIOD_MAX.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, counter=0, period=PERIOD_INIT, duty_act=0, mod_req=0.
  - pwm_out=0, period_wrap=0; at_min/at_max reflect PERIOD_INIT.
- States:
  - IDLE: counter held 0, pwm_out=0, period held.
  - RUN: PWM active.
- IDLE->RUN: on the edge where enable=1.
  - counter<=0; duty_act<=duty.
  - pwm_out<=(0<duty_eff).
  - No wrap pulse and no period step at entry.
- RUN->IDLE: on the edge where enable=0.
  - counter<=0, pwm_out<=0, mod_req<=0.
  - period keeps its value.
- Counting in RUN: counter increments 0..period-1 and wraps to 0.
- pwm_out: registered; on the edge where counter takes value c, pwm_out<=(c<duty_eff).
  - Output is therefore cycle-aligned with counter.
  - duty_eff = min(duty_act, period): duty>=period gives constant high; duty=0 gives constant low.
- Request latch:
  - mod_req sets on any RUN cycle with modify_period=1.
  - A multi-cycle level produces one step per PWM period, never more.
- Wrap edge (counter==period-1), all updates at the same edge:
  - counter<=0; period_wrap<=1 for one cycle.
  - duty_act<=duty.
  - If mod_req=1 or modify_period=1: period<=step(period, direction) and mod_req<=0. A request arriving in the wrap cycle itself is consumed by that wrap.
  - The new period and duty govern the cycle starting at counter=0.
- Step arithmetic: done in N+1 bits.
  - Lengthen: min(period+STEP, PERIOD_MAX).
  - Shorten: max(period-STEP, PERIOD_MIN), with no underflow when period-STEP<0.
  - A request at a limit is consumed with no change.
- at_min/at_max: registered, updated with period.
- Latency:
  - modify_period to new period: effective at the next wrap (<=period cycles).
  - duty change: effective from the next period.
- Simultaneous enable fall and wrap: enable wins; go to IDLE, no step, no wrap pulse.
- Reset mid-run: all state returns to reset values asynchronously; a pending request is lost.

Decomposition:
- Shared package pwm_pkg: state enum typedef (IDLE, RUN) and the parameter legality checks as a function used in elaboration-time assertions.
- One sub-module, period_step_sat: holds the period register, at_min/at_max, and the saturating step logic, with a load-strobe input.
- The counter, FSM, duty buffer and request latch stay in the top.

Test Plan (N=8, PERIOD_MIN=4, PERIOD_MAX=20, PERIOD_INIT=10, STEP=2):
1. Assert n_reset low mid-clock -> pwm_out=0, period_wrap=0, period=10, at_min=0, at_max=0 immediately, without waiting for a clock edge.
2. enable=1, duty=3 -> pwm_out high 3 cycles then low 7; period_wrap every 10 cycles; no pulse at entry.
3. One-cycle modify_period at counter=5, direction=1 -> period becomes 12 at the next wrap and stays 12 afterwards; pwm high 3 of 12.
4. modify_period held high, direction=0, from period 10 -> successive periods 8, 6, 4, 4; at_min=1 once period reaches 4.
5. duty=15 with period 10 -> pwm_out constant 1. duty=0 -> constant 0. duty changed 3->6 at counter=2 -> current period keeps 3 high, next period has 6 high.
6. enable dropped in the wrap cycle with modify_period=1 -> IDLE, pwm_out=0, no period_wrap, period unchanged. Re-enable -> counting restarts at 0.
